adder_8bit: RTL and testbench

- Registered ripple-carry adder: Sum, Cout = A + B + Cin.
- Operand width is WIDTH, default 8.
- One clock cycle of latency, with a valid qualifier on input and output.
- Arithmetic leaf used by datapath blocks that need carry-in and carry-out.

---
 rtl/adder_8bit_pkg.sv | 8 +
 rtl/adder_8bit_full_adder.sv | 19 +
 rtl/adder_8bit.sv | 60 ++++++
 tb/tb_adder_8bit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/adder_8bit_pkg.sv
// rtl/adder_8bit_pkg.sv - shared constants for the registered ripple-carry adder
// Purpose: holds the default operand width used by adder_8bit.
// Ports: none (package).
package adder_8bit_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 8;

endpackage : adder_8bit_pkg

// File: rtl/adder_8bit_full_adder.sv
// rtl/adder_8bit_full_adder.sv - one-bit combinational full-adder cell
// Purpose: single stage of the ripple-carry chain in adder_8bit.
// Ports:
//   a, b  - operand bits
//   cin   - carry into this stage
//   s     - sum bit
//   cout  - carry out of this stage (majority of a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/adder_8bit.sv
// rtl/adder_8bit.sv - registered ripple-carry adder, {Cout,Sum} = A + B + Cin
// Purpose: unsigned WIDTH-bit adder with carry-in/carry-out and one cycle of latency.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - A, B, Cin valid this cycle
//   A, B      - unsigned operands
//   Cin       - carry-in
//   out_valid - Sum/Cout hold a new result this cycle
//   Sum       - registered low WIDTH bits of the sum
//   Cout      - registered carry-out
module adder_8bit
    import adder_8bit_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // Result registers only load on valid input; otherwise they keep the last
    // result while out_valid drops, so consumers must sample in the valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum  <= sum_comb;
                Cout <= carry[WIDTH];
            end
        end
    end

endmodule : adder_8bit

// File: tb/tb_adder_8bit.sv
// tb/tb_adder_8bit.sv - directed and random checks of adder_8bit (WIDTH=8 and WIDTH=4)
module tb_adder_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a, b;
    logic       cin;
    logic       out_valid;
    logic [7:0] sum;
    logic       cout;

    logic [3:0] a4, b4;
    logic       cin4;
    logic       out_valid4;
    logic [3:0] sum4;
    logic       cout4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adder_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .out_valid (out_valid),
        .Sum       (sum),
        .Cout      (cout)
    );

    adder_8bit #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a4),
        .B         (b4),
        .Cin       (cin4),
        .out_valid (out_valid4),
        .Sum       (sum4),
        .Cout      (cout4)
    );

    // Compares {out_valid, Cout, Sum} of the 8-bit instance.
    task automatic check(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {out_valid, cout, sum};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed={v,c,sum}=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {out_valid4, cout4, sum4};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed={v,c,sum}=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one operation, waits one edge, then checks 1 time unit later.
    task automatic op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                      input logic vc, input logic [9:0] exp);
        in_valid = 1'b1;
        a = va; b = vb; cin = vc;
        @(posedge clk); #1;
        check(tag, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;

        // Reset held: inputs toggle with in_valid=1, outputs must stay zero.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            check("reset_hold", 10'h000);
        end

        // Release; first capture on the next edge.
        rst_n = 1'b1;
        op("first_zero", 8'h00, 8'h00, 1'b0, 10'h200);

        // Back-to-back basic sums.
        op("sum_01_01_0", 8'h01, 8'h01, 1'b0, 10'h202);
        op("sum_02_03_0", 8'h02, 8'h03, 1'b0, 10'h205);
        op("sum_05_06_1", 8'h05, 8'h06, 1'b1, 10'h20C);
        op("sum_0f_01_0", 8'h0F, 8'h01, 1'b0, 10'h210);

        // Wrap and carry-out.
        op("wrap_ff_01_0", 8'hFF, 8'h01, 1'b0, 10'h300);
        op("max_ff_ff_1",  8'hFF, 8'hFF, 1'b1, 10'h3FF);
        op("wrap_80_80_0", 8'h80, 8'h80, 1'b0, 10'h300);

        // Hold: result stays, out_valid drops while inputs keep changing.
        op("hold_load", 8'h05, 8'h06, 1'b1, 10'h20C);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            check("hold_idle", 10'h00C);
        end

        // Asynchronous reset between edges.
        op("pre_async", 8'hFF, 8'hFF, 1'b1, 10'h3FF);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 10'h000);
        @(posedge clk); #1;
        check("async_reset_edge", 10'h000);
        rst_n = 1'b1;

        // WIDTH=4 wrap on the second instance.
        in_valid = 1'b1;
        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0;
        @(posedge clk); #1;
        check4("w4_f_1_0", 6'h30);
        check("w4_side_8bit", 10'h200);
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        @(posedge clk); #1;
        check4("w4_f_f_1", 6'h3F);

        // Random sweep, back-to-back, model is plain 9-bit addition.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            logic [8:0] full;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            op("sweep", ra, rb, rc, {1'b1, full});
        end

        in_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_adder_8bit
